// File: rtl/pong_defs.sv
// Shared game-control definitions: state encodings, score width, winner codes.
// Read by the score keeper, the text overlay and the ball logic.
package pong_defs;

  localparam int SCORE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

endpackage

// File: rtl/btn_debounce.sv
// Start-button conditioning: 2-FF synchroniser, frame-paced debounce,
// and a single-cycle pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DEB_FRAMES = 3
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic frame_tick,
  input  logic btn_raw,
  output logic press
);

  localparam int DC_W = $clog2(DEB_FRAMES + 1);
  localparam logic [DC_W-1:0] DEB_N = DC_W'(DEB_FRAMES);

  logic [1:0]      sync;
  logic            cand;
  logic            deb;
  logic [DC_W-1:0] cnt;
  logic            stable;

  assign stable = (cnt == DEB_N);

  // Any change of the synchronised level restarts the stability count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync  <= 2'b00;
      cand  <= 1'b0;
      deb   <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn_raw};
      press <= stable && cand && !deb;
      if (stable)
        deb <= cand;
      if (sync[1] != cand) begin
        cand <= sync[1];
        cnt  <= '0;
      end else if (frame_tick && !stable) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pong_score_keeper.sv
// Game-control stage: owns game state and both scores, and drives the
// overlay's score digits, start-prompt enable and the ball motion enable.
module pong_score_keeper
  import pong_defs::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int DEB_FRAMES   = 3,
  parameter int SERVE_FRAMES = 60
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               p1_miss,
  input  logic               p2_miss,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               start_screen,
  output logic               play_en,
  output logic               serve,
  output logic [1:0]         winner
);

  localparam int SC_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [SC_W-1:0]    SC_LAST = SC_W'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);

  state_t             state;
  logic [SC_W-1:0]    srv_cnt;
  logic               press;
  logic [SCORE_W-1:0] p1_next;
  logic [SCORE_W-1:0] p2_next;

  assign p1_next = p1_score + 1'b1;
  assign p2_next = p2_score + 1'b1;

  btn_debounce #(
    .DEB_FRAMES(DEB_FRAMES)
  ) u_deb (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .frame_tick(frame_tick),
    .btn_raw   (start_btn),
    .press     (press)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= ST_IDLE;
      srv_cnt      <= '0;
      p1_score     <= '0;
      p2_score     <= '0;
      start_screen <= 1'b1;
      play_en      <= 1'b0;
      serve        <= 1'b0;
      winner       <= WINNER_NONE;
    end else begin
      serve <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (press) begin
            state        <= ST_SERVE;
            srv_cnt      <= '0;
            p1_score     <= '0;
            p2_score     <= '0;
            start_screen <= 1'b0;
          end
        end
        ST_SERVE: begin
          if (frame_tick) begin
            if (srv_cnt == SC_LAST) begin
              state   <= ST_PLAY;
              play_en <= 1'b1;
              serve   <= 1'b1;
            end else begin
              srv_cnt <= srv_cnt + 1'b1;
            end
          end
        end
        ST_PLAY: begin
          // Simultaneous misses replay the point without scoring.
          if (p1_miss || p2_miss) begin
            play_en <= 1'b0;
            srv_cnt <= '0;
            state   <= ST_SERVE;
            if (p1_miss && !p2_miss) begin
              p2_score <= p2_next;
              if (p2_next == WIN) begin
                state  <= ST_OVER;
                winner <= WINNER_P2;
              end
            end else if (p2_miss && !p1_miss) begin
              p1_score <= p1_next;
              if (p1_next == WIN) begin
                state  <= ST_OVER;
                winner <= WINNER_P1;
              end
            end
          end
        end
        ST_OVER: begin
          if (press) begin
            state        <= ST_IDLE;
            winner       <= WINNER_NONE;
            start_screen <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
